// File: rtl/vga_timing_gen_if.sv
// Pixel-buffer handshake between the raster timing generator (master) and the
// ping-pong pixel buffer (slave).
interface vga_timing_gen_if #(
    parameter int unsigned PIX_WIDTH = 24
);
    logic                 pix_req_o;
    logic [PIX_WIDTH-1:0] pix_i;
    logic                 pix_valid_i;

    modport master (
        output pix_req_o,
        input  pix_i,
        input  pix_valid_i
    );

    modport slave (
        input  pix_req_o,
        output pix_i,
        output pix_valid_i
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: shadowed resolution config, h/v counters, registered
// sync/DE/RGB outputs, pixel-buffer request, colour-bar self test, sticky underflow.
module vga_timing_gen #(
    parameter int unsigned PIX_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [10:0]          hsync_end_i,
    input  logic [7:0]           hpulse_end_i,
    input  logic [7:0]           hdata_begin_i,
    input  logic [9:0]           hdata_end_i,
    input  logic [8:0]           vsync_end_i,
    input  logic [2:0]           vpulse_end_i,
    input  logic [4:0]           vdata_begin_i,
    input  logic [8:0]           vdata_end_i,
    input  logic                 self_test_i,
    vga_timing_gen_if.master     pix_bus,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic [PIX_WIDTH-1:0] rgb_o,
    output logic                 frame_start_o,
    output logic                 underflow_o
);

    localparam int unsigned HW = 11;
    localparam int unsigned VW = 9;
    localparam int unsigned CW = PIX_WIDTH / 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    logic [10:0] r_hse;
    logic [7:0]  r_hpe;
    logic [7:0]  r_hdb;
    logic [9:0]  r_hde;
    logic [8:0]  r_vse;
    logic [2:0]  r_vpe;
    logic [4:0]  r_vdb;
    logic [8:0]  r_vde;
    logic        r_self_test;

    logic                 w_running;
    logic                 w_frame_last;
    logic                 w_load;
    logic                 w_h_act;
    logic                 w_v_act;
    logic                 w_act;
    logic                 w_hs0;
    logic                 w_vs0;
    logic                 w_fs0;
    logic                 w_req;
    logic [HW-1:0]        w_hoff;
    logic [2:0]           w_bar;
    logic [PIX_WIDTH-1:0] w_rgb0;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Config is recaptured every idle cycle and on the last cycle of each frame
    always_comb begin
        w_running    = (r_state == ST_RUN);
        w_frame_last = (r_hcnt == r_hse) && (r_vcnt == r_vse);
        w_load       = !w_running || w_frame_last;
        w_state_nxt  = r_state;
        if (w_load) begin
            w_state_nxt = ((hsync_end_i != '0) && (vsync_end_i != '0)) ? ST_RUN : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hse       <= '0;
            r_hpe       <= '0;
            r_hdb       <= '0;
            r_hde       <= '0;
            r_vse       <= '0;
            r_vpe       <= '0;
            r_vdb       <= '0;
            r_vde       <= '0;
            r_self_test <= 1'b0;
        end else if (w_load) begin
            r_hse       <= hsync_end_i;
            r_hpe       <= hpulse_end_i;
            r_hdb       <= hdata_begin_i;
            r_hde       <= hdata_end_i;
            r_vse       <= vsync_end_i;
            r_vpe       <= vpulse_end_i;
            r_vdb       <= vdata_begin_i;
            r_vde       <= vdata_end_i;
            r_self_test <= self_test_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || !w_running) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == r_hse) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == r_vse) ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // Stage 0: decode the current raster position; fields are applied literally
    always_comb begin
        w_h_act = (r_hcnt >= HW'(r_hdb)) && (r_hcnt <= HW'(r_hde));
        w_v_act = (r_vcnt >= VW'(r_vdb)) && (r_vcnt <= r_vde);
        w_act   = w_running && w_h_act && w_v_act;
        w_hs0   = !(r_hcnt <= HW'(r_hpe));
        w_vs0   = !(r_vcnt <= VW'(r_vpe));
        w_fs0   = w_running && (r_hcnt == '0) && (r_vcnt == '0);
        w_req   = w_act && !r_self_test;
        w_hoff  = r_hcnt - HW'(r_hdb);
        w_bar   = 3'(w_hoff >> 5);
        w_rgb0  = '0;
        if (w_act) begin
            if (r_self_test) begin
                w_rgb0 = PIX_WIDTH'({{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}});
            end else if (pix_bus.pix_valid_i) begin
                w_rgb0 = pix_bus.pix_i;
            end
        end
    end

    assign pix_bus.pix_req_o = w_req;

    always_ff @(posedge clk) begin
        if (!resetn || !w_running) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            de_o          <= 1'b0;
            rgb_o         <= '0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= w_hs0;
            vsync_o       <= w_vs0;
            de_o          <= w_act;
            rgb_o         <= w_rgb0;
            frame_start_o <= w_fs0;
        end
    end

    // Sticky underflow: a miss on the frame-start cycle still sets it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            underflow_o <= 1'b0;
        end else if (w_req && !pix_bus.pix_valid_i) begin
            underflow_o <= 1'b1;
        end else if (w_fs0) begin
            underflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: linear-position raster model compared every
// cycle, plus hand-computed frame/line/latency/colour-bar expectations.
module tb_vga_timing_gen;

    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          resetn;
    logic [10:0]   hse;
    logic [7:0]    hpe;
    logic [7:0]    hdb;
    logic [9:0]    hde;
    logic [8:0]    vse;
    logic [2:0]    vpe;
    logic [4:0]    vdb;
    logic [8:0]    vde;
    logic          st;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic [PW-1:0] rgb_o;
    logic          frame_start_o;
    logic          underflow_o;

    int n_checks = 0;
    int n_errors = 0;
    int pix_n    = 0;

    vga_timing_gen_if #(.PIX_WIDTH(PW)) u_if ();

    vga_timing_gen #(.PIX_WIDTH(PW)) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .hsync_end_i   (hse),
        .hpulse_end_i  (hpe),
        .hdata_begin_i (hdb),
        .hdata_end_i   (hde),
        .vsync_end_i   (vse),
        .vpulse_end_i  (vpe),
        .vdata_begin_i (vdb),
        .vdata_end_i   (vde),
        .self_test_i   (st),
        .pix_bus       (u_if),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .rgb_o         (rgb_o),
        .frame_start_o (frame_start_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] bar_rgb(input int off);
        int b;
        b = (off >> 5) & 7;
        bar_rgb = (((b & 4) != 0) ? 24'hFF0000 : 24'h0) |
                  (((b & 2) != 0) ? 24'h00FF00 : 24'h0) |
                  (((b & 1) != 0) ? 24'h0000FF : 24'h0);
    endfunction

    // Buffer side: a new counting pixel every cycle
    always @(posedge clk) begin
        #1;
        u_if.pix_i = 24'h00AB00 + PW'(pix_n);
        pix_n++;
    end

    // Reference model: raster position as a single index t into the frame
    int m_hse, m_hpe, m_hdb, m_hde, m_vse, m_vpe, m_vdb, m_vde, m_t;
    bit m_st, m_run, m_uf;
    bit m_known = 1'b0;
    bit e_valid = 1'b0;
    bit e_hs, e_vs, e_de, e_fs, e_uf;
    logic [PW-1:0] e_rgb;

    always @(negedge clk) begin : model
        int line, flen, h, v;
        bit act, req, last;
        if (e_valid) begin
            chk("m_hsync", hsync_o, e_hs);
            chk("m_vsync", vsync_o, e_vs);
            chk("m_de", de_o, e_de);
            chk("m_rgb", rgb_o, e_rgb);
            chk("m_fs", frame_start_o, e_fs);
            chk("m_uf", underflow_o, e_uf);
        end
        line = m_hse + 1;
        flen = line * (m_vse + 1);
        h    = m_t % line;
        v    = m_t / line;
        act  = m_run && h >= m_hdb && h <= m_hde && v >= m_vdb && v <= m_vde;
        req  = act && !m_st;
        if (m_known) chk("m_pix_req", u_if.pix_req_o, req);
        if (!resetn) begin
            {m_hse, m_hpe, m_hdb, m_hde, m_vse, m_vpe, m_vdb, m_vde, m_t} = '0;
            m_st = 0; m_run = 0; m_uf = 0;
            e_hs = 1; e_vs = 1; e_de = 0; e_rgb = '0; e_fs = 0; e_uf = 0;
            m_known = 1; e_valid = 1;
        end else if (m_known) begin
            e_hs = m_run ? (h > m_hpe) : 1'b1;
            e_vs = m_run ? (v > m_vpe) : 1'b1;
            e_de = act;
            e_fs = m_run && m_t == 0;
            if (!act) e_rgb = '0;
            else if (m_st) e_rgb = bar_rgb(h - m_hdb);
            else if (u_if.pix_valid_i) e_rgb = u_if.pix_i;
            else e_rgb = '0;
            if (req && !u_if.pix_valid_i) m_uf = 1;
            else if (m_run && m_t == 0) m_uf = 0;
            e_uf = m_uf;
            last = m_run && (m_t == flen - 1);
            m_t  = (m_run && !last) ? m_t + 1 : 0;
            if (!m_run || last) begin
                m_hse = int'(hse); m_hpe = int'(hpe); m_hdb = int'(hdb); m_hde = int'(hde);
                m_vse = int'(vse); m_vpe = int'(vpe); m_vdb = int'(vdb); m_vde = int'(vde);
                m_st  = st;
                m_run = (hse != 0) && (vse != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (frame_start_o !== 1'b1 && cyc < 5000);
        if (frame_start_o !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL fs_timeout got=%b exp=1 t=%0t", frame_start_o, $time);
        end
    endtask

    task automatic cfg_a();
        hse = 11'd15; hpe = 8'd1; hdb = 8'd3; hde = 10'd12;
        vse = 9'd9;   vpe = 3'd0; vdb = 5'd2; vde = 9'd7; st = 1'b0;
    endtask

    initial begin
        int n, k, cyc, de_cnt, hs_cnt, vs_cnt, fs_cnt, w;
        logic [PW-1:0] saved;
        resetn = 1'b0;
        {hse, hpe, hdb, hde, vse, vpe, vdb, vde, st} = '0;
        u_if.pix_i       = '0;
        u_if.pix_valid_i = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_hsync", hsync_o, 1);
        chk("rst_vsync", vsync_o, 1);
        chk("rst_de", de_o, 0);
        chk("rst_rgb", rgb_o, 0);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_uf", underflow_o, 0);
        chk("rst_req", u_if.pix_req_o, 0);
        tick();
        resetn = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        chk("idle_hsync", hsync_o, 1);
        chk("idle_vsync", vsync_o, 1);
        chk("idle_de", de_o, 0);

        // Cfg A from idle: first frame_start one clock after running
        tick();
        cfg_a();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start_o !== 1'b1 && n < 50);
        chk("first_fs_lat", n, 3);

        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            de_cnt += int'(de_o);
            hs_cnt += int'(!hsync_o);
            vs_cnt += int'(!vsync_o);
            fs_cnt += int'(frame_start_o);
            @(negedge clk);
        end
        chk("de_per_frame", de_cnt, 60);
        chk("hs_low_per_frame", hs_cnt, 20);
        chk("vs_low_per_frame", vs_cnt, 16);
        chk("fs_per_frame", fs_cnt, 1);
        chk("fs_period", frame_start_o, 1);

        k = 0;
        while (u_if.pix_req_o !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("req_first", k, 34);
        chk("req_de_low", de_o, 0);
        saved = u_if.pix_i;
        @(negedge clk);
        chk("de_after_req", de_o, 1);
        chk("rgb_first", rgb_o, saved);

        // Drop one pixel on line 4 (h=5)
        repeat (33) tick();
        u_if.pix_valid_i = 1'b0;
        tick();
        u_if.pix_valid_i = 1'b1;
        @(negedge clk);
        chk("uf_set", underflow_o, 1);
        chk("uf_de", de_o, 1);
        chk("uf_rgb", rgb_o, 0);
        wait_fs(cyc);
        chk("uf_clear", underflow_o, 0);

        // Line length change mid-frame takes effect at the next frame
        tick();
        hse = 11'd31;
        wait_fs(cyc);
        chk("frame_old_len", cyc, 160);
        wait_fs(cyc);
        chk("frame_new_len", cyc, 320);

        // Colour bars
        tick();
        st = 1'b1; hdb = 8'd0; hde = 10'd255; hse = 11'd300;
        wait_fs(cyc);
        k = 0;
        while (de_o !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("bar_de_found", de_o, 1);
        for (int p = 0; p < 256; p++) begin
            chk("bar_rgb", rgb_o, bar_rgb(p));
            chk("bar_no_req", u_if.pix_req_o, 0);
            @(negedge clk);
        end
        chk("bar_de_end", de_o, 0);

        // Reset in the middle of a line
        tick();
        cfg_a();
        wait_fs(cyc);
        wait_fs(cyc);
        repeat (40) begin
            tick();
            u_if.pix_valid_i = ($urandom % 3) != 0;
        end
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_hsync", hsync_o, 1);
        chk("rmid_vsync", vsync_o, 1);
        chk("rmid_de", de_o, 0);
        chk("rmid_rgb", rgb_o, 0);
        chk("rmid_fs", frame_start_o, 0);
        chk("rmid_uf", underflow_o, 0);
        chk("rmid_req", u_if.pix_req_o, 0);
        tick();
        resetn = 1'b1;

        // Random configs (including degenerate fields) applied at random times
        for (int r = 0; r < 6; r++) begin
            w = $urandom_range(0, 60);
            repeat (w) begin
                tick();
                u_if.pix_valid_i = ($urandom % 4) != 0;
            end
            hse = 11'($urandom_range(8, 40));
            hpe = 8'($urandom_range(0, 45));
            hdb = 8'($urandom_range(0, 30));
            hde = 10'($urandom_range(0, 45));
            vse = 9'($urandom_range(2, 10));
            vpe = 3'($urandom_range(0, 7));
            vdb = 5'($urandom_range(0, 8));
            vde = 9'($urandom_range(0, 12));
            st  = ($urandom % 4) == 0;
            repeat (3 * (int'(hse) + 1) * (int'(vse) + 1)) begin
                tick();
                u_if.pix_valid_i = ($urandom % 4) != 0;
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
